// File: rtl/instruction_sequencer.sv
// Fetch/issue stage: loadable program memory of datapath words, issued one per
// cycle after start, with hold bubbles, optional stop on the datapath zero flag
// and a count of zero-flag hits over the run.
module instruction_sequencer #(
   parameter int unsigned INSTR_W = 17,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned AW      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_en,
   input  logic [AW-1:0]      load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               start,
   input  logic [AW:0]        prog_len,
   input  logic               stop_on_zero,
   input  logic               hold,
   input  logic               z_flag,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic               busy,
   output logic               done,
   output logic [AW:0]        zero_count
);

   localparam logic [AW:0] DepthLen = DEPTH[AW:0];

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [AW:0]        pc_q, pc_d;
   logic [AW:0]        len_q, len_d;
   logic [AW:0]        zero_count_q, zero_count_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;

   logic [INSTR_W-1:0] mem [DEPTH];

   // Program memory write; blocked while a run is in flight. Not reset.
   always_ff @(posedge clk) begin
      if (load_en && (state_q != StRun)) begin
         mem[load_addr] <= load_data;
      end
   end

   // Next-state, issue and zero-count logic. Every edge defaults to a bubble.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      len_d        = len_q;
      instr_d      = '0;
      valid_d      = 1'b0;
      zero_count_d = zero_count_q + {{AW{1'b0}}, (valid_q & z_flag)};
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               len_d        = (prog_len > DepthLen) ? DepthLen : prog_len;
               pc_d         = '0;
               zero_count_d = '0;
               if (len_d == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StRun;
                  if (!hold) begin
                     // Old mem[0] is read even if it is being loaded this edge.
                     instr_d = mem[{AW{1'b0}}];
                     valid_d = 1'b1;
                     pc_d    = {{AW{1'b0}}, 1'b1};
                  end
               end
            end
         end
         StRun: begin
            if (valid_q && z_flag && stop_on_zero) begin
               state_d = StDone;
            end else if (pc_q == len_q) begin
               state_d = StDone;
            end else if (!hold) begin
               instr_d = mem[pc_q[AW-1:0]];
               valid_d = 1'b1;
               pc_d    = pc_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and registered outputs; reset clears them asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= '0;
         len_q        <= '0;
         zero_count_q <= '0;
         instr_q      <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         len_q        <= len_d;
         zero_count_q <= zero_count_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
      end
   end

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);
   assign zero_count  = zero_count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer. The reference model treats a
// run as a queue of words to issue (truncated at the first zero-flag word when
// stop_on_zero is set); each sampled hold inserts a bubble, and an empty queue
// means the run is done.
module tb_instruction_sequencer;

   localparam int INSTR_W = 17;
   localparam int DEPTH   = 16;
   localparam int AW      = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               load_en = 1'b0;
   logic [AW-1:0]      load_addr = '0;
   logic [INSTR_W-1:0] load_data = '0;
   logic               start = 1'b0;
   logic [AW:0]        prog_len = '0;
   logic               stop_on_zero = 1'b0;
   logic               hold = 1'b0;
   logic               z_flag = 1'b0;
   logic [INSTR_W-1:0] instruction;
   logic               instr_valid;
   logic               busy;
   logic               done;
   logic [AW:0]        zero_count;

   int vectors = 0;
   int miscompares = 0;
   logic [INSTR_W-1:0] model_mem [DEPTH];

   instruction_sequencer #(
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH),
      .AW      (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .start        (start),
      .prog_len     (prog_len),
      .stop_on_zero (stop_on_zero),
      .hold         (hold),
      .z_flag       (z_flag),
      .instruction  (instruction),
      .instr_valid  (instr_valid),
      .busy         (busy),
      .done         (done),
      .zero_count   (zero_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input int addr, input logic [INSTR_W-1:0] data);
      load_en   = 1'b1;
      load_addr = addr[AW-1:0];
      load_data = data;
      tick();
      load_en = 1'b0;
      model_mem[addr] = data;
   endtask

   task automatic load_random_all();
      for (int a = 0; a < DEPTH; a++) begin
         load_word(a, INSTR_W'($urandom));
      end
   endtask

   // One complete run checked cycle by cycle against the queue model.
   task automatic run_prog(input int len, input bit soz, input int hold_pct, input int z_pct,
                           input bit guard_load, input bit start_load0, input string name);
      logic [INSTR_W-1:0] pending [$];
      bit                 zq [$];
      logic [INSTR_W-1:0] cur_word;
      logic [INSTR_W-1:0] exp_instr;
      bit                 zm, cur_z, cur_valid, finished, prev_valid, prev_z;
      int                 n, zc_exp, cyc;
      n = (len > DEPTH) ? DEPTH : len;
      for (int j = 0; j < n; j++) begin
         zm = ($urandom_range(99) < z_pct);
         pending.push_back(model_mem[j]);
         zq.push_back(zm);
         if (soz && zm) break;
      end
      stop_on_zero = soz;
      prog_len     = len[AW:0];
      start        = 1'b1;
      hold         = ($urandom_range(99) < hold_pct);
      if (start_load0) begin
         load_en   = 1'b1;
         load_addr = '0;
         load_data = INSTR_W'($urandom);
      end
      zc_exp = 0; prev_valid = 0; prev_z = 0; finished = 0; cyc = 0;
      cur_word = '0; cur_z = 0;
      while (!finished && cyc < 100) begin
         tick();
         start   = 1'b0;
         load_en = 1'b0;
         if (start_load0 && cyc == 0) model_mem[0] = load_data;
         if (prev_valid && prev_z) zc_exp++;
         if (pending.size() == 0) begin
            finished  = 1;
            cur_valid = 0;
         end else if (hold) begin
            cur_valid = 0;
         end else begin
            cur_valid = 1;
            cur_word  = pending.pop_front();
            cur_z     = zq.pop_front();
         end
         exp_instr = cur_valid ? cur_word : '0;
         vectors++;
         if (instr_valid !== cur_valid) begin
            miscompares++;
            $display("FAIL %s cyc %0d instr_valid: got %b want %b", name, cyc, instr_valid,
                     cur_valid);
         end
         vectors++;
         if (instruction !== exp_instr) begin
            miscompares++;
            $display("FAIL %s cyc %0d instruction: got %h want %h", name, cyc, instruction,
                     exp_instr);
         end
         vectors++;
         if (busy !== !finished) begin
            miscompares++;
            $display("FAIL %s cyc %0d busy: got %b want %b", name, cyc, busy, !finished);
         end
         vectors++;
         if (done !== finished) begin
            miscompares++;
            $display("FAIL %s cyc %0d done: got %b want %b", name, cyc, done, finished);
         end
         vectors++;
         if (zero_count !== zc_exp[AW:0]) begin
            miscompares++;
            $display("FAIL %s cyc %0d zero_count: got %0d want %0d", name, cyc, zero_count,
                     zc_exp);
         end
         // Drive the next edge's inputs; z on a bubble is random and must be ignored.
         z_flag     = cur_valid ? cur_z : 1'($urandom);
         hold       = ($urandom_range(99) < hold_pct);
         prev_valid = cur_valid;
         prev_z     = z_flag;
         if (guard_load && cyc == 1 && !finished) begin
            load_en   = 1'b1;
            load_addr = 4'd2;
            load_data = ~model_mem[2];
         end
         cyc++;
      end
      vectors++;
      if (!finished) begin
         miscompares++;
         $display("FAIL %s timeout: got %0d cycles want completion", name, cyc);
      end
      z_flag = 1'b0; hold = 1'b0; stop_on_zero = 1'b0; load_en = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if ({instruction, instr_valid, busy, done, zero_count} !== '0) begin
         miscompares++;
         $display("FAIL reset outputs: got %h/%b/%b/%b/%0d want all zero", instruction,
                  instr_valid, busy, done, zero_count);
      end
      #10;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      load_word(0, 17'h0A5A3);
      load_word(1, 17'h12221);
      load_word(2, 17'h1FFFF);
      run_prog(3, 0, 0, 0, 0, 0, "basic");
   endtask

   task automatic test_hold();
      load_random_all();
      run_prog(4, 0, 40, 20, 0, 0, "hold4");
      for (int i = 0; i < 5; i++) begin
         run_prog(int'($urandom_range(16, 1)), 0, 40, 30, 0, 0, "hold_rand");
      end
   endtask

   task automatic test_stop_on_zero();
      for (int i = 0; i < 8; i++) begin
         run_prog(int'($urandom_range(16, 1)), 1, 25, 30, 0, 0, "stop_zero");
      end
   endtask

   task automatic test_len_bounds();
      run_prog(0, 0, 0, 0, 0, 0, "len0");
      run_prog(20, 0, 0, 10, 0, 0, "len20");
      run_prog(16, 0, 20, 10, 0, 0, "len16");
      run_prog(31, 0, 0, 0, 0, 0, "len31");
   endtask

   task automatic test_guards();
      prog_len = 5'd10; start = 1'b1; hold = 1'b0; stop_on_zero = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      vectors++;
      if (instr_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL midrun instr_valid: got %b want 1", instr_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({instr_valid, busy, done, instruction, zero_count} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got v%b b%b d%b i%h z%0d want all zero", instr_valid,
                  busy, done, instruction, zero_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_prog(4, 0, 0, 0, 1, 0, "guard_load");
      run_prog(4, 0, 0, 0, 0, 0, "guard_rerun");
   endtask

   task automatic test_restart();
      run_prog(4, 0, 0, 100, 0, 0, "zc_fill");
      run_prog(2, 0, 0, 0, 0, 0, "restart");
      run_prog(3, 0, 10, 0, 0, 1, "start_load0");
      run_prog(3, 0, 0, 0, 0, 0, "after_load0");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_stop_on_zero();
      test_len_bounds();
      test_guards();
      test_restart();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
